hdmi_video_timing: RTL and testbench

HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

---
 rtl/hdmi_pkg.sv | 31 +++
 rtl/hdmi_period_fsm.sv | 119 +++++++++++
 rtl/hdmi_video_timing.sv | 144 ++++++++++++++
 tb/tb_hdmi_video_timing.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI period definitions: encoder period codes, preamble CTL pattern,
// and preamble/guard-band lengths used by the period FSM.
package hdmi_pkg;

  // Period code presented to the TMDS encoder.
  typedef enum logic [1:0] {
    PERIOD_CTRL   = 2'd0,
    PERIOD_ISLAND = 2'd1,
    PERIOD_VIDEO  = 2'd2
  } period_e;

  // Internal period FSM states.
  typedef enum logic [1:0] {
    FSM_CTRL,
    FSM_PREAMBLE,
    FSM_GUARD,
    FSM_VIDEO
  } fsm_state_e;

  localparam logic [3:0]  CTL_IDLE           = 4'b0000;
  localparam logic [3:0]  CTL_PREAMBLE_VIDEO = 4'b0001;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned GUARD_LEN    = 2;

  // Guard band is encoded with the video period code.
  function automatic period_e period_of(input fsm_state_e s);
    return ((s == FSM_GUARD) || (s == FSM_VIDEO)) ? PERIOD_VIDEO : PERIOD_CTRL;
  endfunction

endpackage

// File: rtl/hdmi_period_fsm.sv
// Period FSM (CTRL / PREAMBLE / GUARD / VIDEO) driven by the raster counters.
// HDMI_VIDEO_TIMING_GUARD_EN enables preamble and guard band; without it the
// block runs in DVI mode (CTRL/VIDEO only, ctl and guard tied low).
// The FSM register is updated from the same counter values that feed the
// top-level output registers, so state/ctl/guard align with de, x, y.
module hdmi_period_fsm
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
`ifdef HDMI_VIDEO_TIMING_GUARD_EN
  ,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525
`endif
) (
  input  logic        clklow,
  input  logic        reset,
  input  logic        en,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  output logic [1:0]  state,
  output logic [3:0]  ctl,
  output logic        guard
);

  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);

  fsm_state_e fsm_q, fsm_d;
  logic       active;

`ifdef HDMI_VIDEO_TIMING_GUARD_EN
  // Preamble must start early enough that preamble + guard end on the last pixel.
  localparam logic [11:0] H_PRE    = 12'(H_TOTAL - (PREAMBLE_LEN + GUARD_LEN));
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [2:0]  PRE_LAST = 3'(PREAMBLE_LEN - 1);
  localparam logic [2:0]  GRD_LAST = 3'(GUARD_LEN - 1);

  logic [2:0] phase_q, phase_d;
  logic       next_line_active;

  // Next-state: preamble before every active line, then guard, then video.
  always_comb begin
    active           = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    next_line_active = ((v_cnt + 12'd1) < V_ACT) || (v_cnt == V_LAST);
    fsm_d            = fsm_q;
    phase_d          = phase_q;
    if (en) begin
      unique case (fsm_q)
        FSM_CTRL: begin
          if ((h_cnt == H_PRE) && next_line_active) begin
            fsm_d   = FSM_PREAMBLE;
            phase_d = '0;
          end
        end
        FSM_PREAMBLE: begin
          if (phase_q == PRE_LAST) begin
            fsm_d   = FSM_GUARD;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
        FSM_GUARD: begin
          if (phase_q == GRD_LAST) begin
            fsm_d   = FSM_VIDEO;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
        FSM_VIDEO: begin
          if (!active) fsm_d = FSM_CTRL;
        end
      endcase
    end
  end

  // State and phase registers.
  always_ff @(posedge clklow or negedge reset) begin
    if (!reset) begin
      fsm_q   <= FSM_CTRL;
      phase_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      phase_q <= phase_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    state = period_of(fsm_q);
    ctl   = (fsm_q == FSM_PREAMBLE) ? CTL_PREAMBLE_VIDEO : CTL_IDLE;
    guard = (fsm_q == FSM_GUARD);
  end
`else
  // Next-state: DVI mode simply tracks the active region.
  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    fsm_d  = fsm_q;
    if (en) fsm_d = active ? FSM_VIDEO : FSM_CTRL;
  end

  // State register.
  always_ff @(posedge clklow or negedge reset) begin
    if (!reset) fsm_q <= FSM_CTRL;
    else        fsm_q <= fsm_d;
  end

  // Output decode; no preamble or guard band in DVI mode.
  always_comb begin
    state = period_of(fsm_q);
    ctl   = CTL_IDLE;
    guard = 1'b0;
  end
`endif

endmodule

// File: rtl/hdmi_video_timing.sv
// HDMI/DVI video timing generator: raster counters, sync/de/x/y generation
// with one cycle of registered latency, and the encoder period FSM.
// Optional feature macro: HDMI_VIDEO_TIMING_GUARD_EN (preamble + guard band).
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clklow,
  input  logic        reset,
  input  logic        en,
  output logic [1:0]  state,
  output logic [1:0]  H_VSync_Ctr,
  output logic [3:0]  ctl,
  output logic        guard,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef HDMI_VIDEO_TIMING_GUARD_EN
  // Preamble + guard must fit inside the horizontal back porch.
  if (H_BP < PREAMBLE_LEN + GUARD_LEN) begin : g_bp_too_short
    $error("H_BP too short for preamble and guard band");
  end
`endif

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic        active;

  // Raster counters advance only while enabled; the line wrap steps the row.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
      end
    end
  end

  // Pixel-level decode of the current counters, held while disabled.
  always_comb begin
    active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = frame_start_q;
    if (en) begin
      de_d          = active;
      x_d           = active ? h_cnt_q : '0;
      y_d           = active ? v_cnt_q : '0;
      hsync_d       = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? VS_POL : ~VS_POL;
      frame_start_d = active && (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // Counter and output registers; reset drives syncs to their idle level.
  always_ff @(posedge clklow or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Drive ports from the registers.
  always_comb begin
    de          = de_q;
    x           = x_q;
    y           = y_q;
    H_VSync_Ctr = {vsync_q, hsync_q};
    frame_start = frame_start_q;
  end

  hdmi_period_fsm #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
`ifdef HDMI_VIDEO_TIMING_GUARD_EN
    ,
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL)
`endif
  ) u_period_fsm (
    .clklow (clklow),
    .reset  (reset),
    .en     (en),
    .h_cnt  (h_cnt_q),
    .v_cnt  (v_cnt_q),
    .state  (state),
    .ctl    (ctl),
    .guard  (guard)
  );

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing: a default-timing instance plus a
// small-raster instance (fast frame wrap / vsync coverage). Expected output
// words are hand-computed and queued per clock edge; a monitor compares them.
module tb_hdmi_video_timing;

`ifdef HDMI_VIDEO_TIMING_GUARD_EN
  localparam bit GM = 1'b1;
`else
  localparam bit GM = 1'b0;
`endif
  // Mode-dependent expectations.
  localparam logic [1:0] ST_L0   = GM ? 2'd0 : 2'd2;   // state on line 0 of first frame
  localparam logic [1:0] ST_G    = GM ? 2'd2 : 2'd0;   // state during guard slots
  localparam logic [3:0] CTL_PRE = GM ? 4'b0001 : 4'b0000;
  localparam logic       G       = GM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic en_s = 1'b1;

  logic [1:0]  st0, sy0, st1, sy1;
  logic [3:0]  ctl0, ctl1;
  logic        g0, g1, de0, de1, fs0, fs1;
  logic [11:0] x0, y0, x1, y1;

  always #5 clk = ~clk;

  hdmi_video_timing u_dut (
    .clklow(clk), .reset(rst_n), .en(en),
    .state(st0), .H_VSync_Ctr(sy0), .ctl(ctl0), .guard(g0),
    .de(de0), .x(x0), .y(y0), .frame_start(fs0)
  );

  hdmi_video_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(10),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .clklow(clk), .reset(rst_n), .en(en_s),
    .state(st1), .H_VSync_Ctr(sy1), .ctl(ctl1), .guard(g1),
    .de(de1), .x(x1), .y(y1), .frame_start(fs1)
  );

  typedef struct {
    int          e;
    bit          w;
    string       name;
    logic [34:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_t;
  int   edge_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   dvi_viol = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [34:0] pk(input logic [1:0] st, input logic [1:0] sy,
                                     input logic [3:0] c, input logic g, input logic d,
                                     input int xx, input int yy, input logic fs);
    return {st, sy, c, g, d, 12'(xx), 12'(yy), fs};
  endfunction

  function automatic logic [34:0] act0();
    return {st0, sy0, ctl0, g0, de0, x0, y0, fs0};
  endfunction

  function automatic logic [34:0] act1();
    return {st1, sy1, ctl1, g1, de1, x1, y1, fs1};
  endfunction

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d act{st,sync,ctl,g,de,x,y,fs}=%h exp=%h", name, edge_cnt, act, exp);
    end
  endtask

  // Sorted insert so the monitor can always look at the queue head.
  task automatic push(input int e, input bit w, input string n, input logic [34:0] v);
    exp_t t;
    int   i;
    t.e = e; t.w = w; t.name = n; t.v = v;
    i = sb.size();
    while (i > 0 && sb[i-1].e > e) i--;
    sb.insert(i, t);
  endtask

  task automatic at_neg(input int n);
    @(negedge clk);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_cnt) begin
      mon_t = sb.pop_front();
      if (mon_t.e < edge_cnt) begin
        checks++;
        failures++;
        $display("FAIL %s missed: due edge %0d, now %0d", mon_t.name, mon_t.e, edge_cnt);
      end else begin
        chk(mon_t.name, mon_t.w ? act1() : act0(), mon_t.v);
      end
    end
  end

`ifndef HDMI_VIDEO_TIMING_GUARD_EN
  // DVI: state must equal 2*de with ctl/guard low on every cycle.
  always @(negedge clk) begin
    if (st0 !== {de0, 1'b0} || ctl0 !== 4'b0 || g0 !== 1'b0) dvi_viol++;
    if (st1 !== {de1, 1'b0} || ctl1 !== 4'b0 || g1 !== 1'b0) dvi_viol++;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", edge_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held: idle outputs.
    push(1, 1'b0, "d_rst_state", pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(2, 1'b1, "s_rst_state", pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    at_neg(2);
    #2 rst_n = 1'b1;

    // Default raster: output at edge E shows counter k = E-3.
    push(3,    1'b0, "d_first_px",   pk(ST_L0, 2'b11, 4'b0, 1'b0, 1'b1, 0, 0, 1'b1));
    push(4,    1'b0, "d_px1",        pk(ST_L0, 2'b11, 4'b0, 1'b0, 1'b1, 1, 0, 1'b0));
    push(642,  1'b0, "d_last_act",   pk(ST_L0, 2'b11, 4'b0, 1'b0, 1'b1, 639, 0, 1'b0));
    push(643,  1'b0, "d_de_fall",    pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(658,  1'b0, "d_pre_hs",     pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(659,  1'b0, "d_hs_start",   pk(2'd0, 2'b10, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(754,  1'b0, "d_hs_end",     pk(2'd0, 2'b10, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(755,  1'b0, "d_hs_off",     pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(793,  1'b0, "d_pre_start",  pk(2'd0, 2'b11, CTL_PRE, 1'b0, 1'b0, 0, 0, 1'b0));
    push(800,  1'b0, "d_pre_last",   pk(2'd0, 2'b11, CTL_PRE, 1'b0, 1'b0, 0, 0, 1'b0));
    push(801,  1'b0, "d_guard0",     pk(ST_G, 2'b11, 4'b0, G, 1'b0, 0, 0, 1'b0));
    push(802,  1'b0, "d_guard1",     pk(ST_G, 2'b11, 4'b0, G, 1'b0, 0, 0, 1'b0));
    push(803,  1'b0, "d_line1",      pk(2'd2, 2'b11, 4'b0, 1'b0, 1'b1, 0, 1, 1'b0));
    push(1602, 1'b0, "d_line1_grd",  pk(ST_G, 2'b11, 4'b0, G, 1'b0, 0, 0, 1'b0));

    // Small raster: 32 x 9, hsync h18..21, vsync v5..6, active-high syncs.
    push(3,   1'b1, "s_first_px",    pk(ST_L0, 2'b00, 4'b0, 1'b0, 1'b1, 0, 0, 1'b1));
    push(18,  1'b1, "s_last_act",    pk(ST_L0, 2'b00, 4'b0, 1'b0, 1'b1, 15, 0, 1'b0));
    push(19,  1'b1, "s_de_fall",     pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(21,  1'b1, "s_hs_start",    pk(2'd0, 2'b01, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(24,  1'b1, "s_hs_end",      pk(2'd0, 2'b01, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(25,  1'b1, "s_pre_start",   pk(2'd0, 2'b00, CTL_PRE, 1'b0, 1'b0, 0, 0, 1'b0));
    push(33,  1'b1, "s_guard",       pk(ST_G, 2'b00, 4'b0, G, 1'b0, 0, 0, 1'b0));
    push(35,  1'b1, "s_line1",       pk(2'd2, 2'b00, 4'b0, 1'b0, 1'b1, 0, 1, 1'b0));
    push(121, 1'b1, "s_no_pre_l3",   pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(130, 1'b1, "s_no_grd_l3",   pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(131, 1'b1, "s_v_fp",        pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(163, 1'b1, "s_vs_start",    pk(2'd0, 2'b10, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(181, 1'b1, "s_vs_hs",       pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(227, 1'b1, "s_vs_off",      pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(281, 1'b1, "s_pre_wrap",    pk(2'd0, 2'b00, CTL_PRE, 1'b0, 1'b0, 0, 0, 1'b0));
    push(289, 1'b1, "s_guard_wrap",  pk(ST_G, 2'b00, 4'b0, G, 1'b0, 0, 0, 1'b0));
    push(291, 1'b1, "s_frame_wrap",  pk(2'd2, 2'b00, 4'b0, 1'b0, 1'b1, 0, 0, 1'b1));
    push(292, 1'b1, "s_frame_px1",   pk(2'd2, 2'b00, 4'b0, 1'b0, 1'b1, 1, 0, 1'b0));

    // Freeze the default instance with h_cnt=300 on line 2 (output shows x=299).
    at_neg(1902);
    #2 en = 1'b0;
    push(1903, 1'b0, "d_freeze_a",   pk(2'd2, 2'b11, 4'b0, 1'b0, 1'b1, 299, 2, 1'b0));
    push(1952, 1'b0, "d_freeze_b",   pk(2'd2, 2'b11, 4'b0, 1'b0, 1'b1, 299, 2, 1'b0));
    at_neg(1952);
    #2 en = 1'b1;
    // After 50 frozen edges: output at edge E shows k = E-53.
    push(1953, 1'b0, "d_resume",     pk(2'd2, 2'b11, 4'b0, 1'b0, 1'b1, 300, 2, 1'b0));
    push(1954, 1'b0, "d_resume_1",   pk(2'd2, 2'b11, 4'b0, 1'b0, 1'b1, 301, 2, 1'b0));
    push(3152, 1'b0, "d_pre_rst",    pk(2'd0, 2'b10, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));

    // Mid-cycle reset with h_cnt=700 on line 3.
    at_neg(3152);
    #2 rst_n = 1'b0;
    #1;
    chk("d_async_rst", act0(), pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    chk("s_async_rst", act1(), pk(2'd0, 2'b00, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    push(3154, 1'b0, "d_rst_hold",   pk(2'd0, 2'b11, 4'b0, 1'b0, 1'b0, 0, 0, 1'b0));
    at_neg(3154);
    #2 rst_n = 1'b1;
    push(3155, 1'b0, "d_restart",    pk(ST_L0, 2'b11, 4'b0, 1'b0, 1'b1, 0, 0, 1'b1));
    push(3156, 1'b0, "d_restart_1",  pk(ST_L0, 2'b11, 4'b0, 1'b0, 1'b1, 1, 0, 1'b0));
    push(3155, 1'b1, "s_restart",    pk(ST_L0, 2'b00, 4'b0, 1'b0, 1'b1, 0, 0, 1'b1));

    at_neg(3160);
    #2;
    while (sb.size() > 0) begin
      mon_t = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s never compared (due edge %0d)", mon_t.name, mon_t.e);
    end
`ifndef HDMI_VIDEO_TIMING_GUARD_EN
    checks++;
    if (dvi_viol != 0) begin
      failures++;
      $display("FAIL dvi_state_eq_2de violations=%0d required=0", dvi_viol);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
